// File: rtl/gmii_rx_frame_parser.sv
// GMII receive front end: preamble/SFD delineation, header field tracking and a one-cycle frame-end verdict.
// Define RX_CRC_CHECK_EN to build the CRC32 engine; otherwise the verdict uses length and igmii_er only.
`timescale 1ns/1ps
module gmii_rx_frame_parser #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGHT = 64,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pFSM_BUS_WIDHT     = 3
) (
  input  logic                      iclk,
  input  logic                      irst,
  input  logic                      igmii_dv,
  input  logic [pDATA_WIDTH-1:0]    igmii_d,
  input  logic                      igmii_er,
  output logic                      odv,
  output logic [pDATA_WIDTH-1:0]    orx_d,
  output logic                      orx_er,
  output logic [pFSM_BUS_WIDHT-1:0] oframe_state,
  output logic                      ostatus_valid,
  output logic [10:0]               olen
);

  typedef enum logic [2:0] {
    lpIDLE     = 3'd0,
    lpPREAMBLE = 3'd1,
    lpSFD      = 3'd2,
    lpDA       = 3'd3,
    lpSA       = 3'd4,
    lpTYPE     = 3'd5,
    lpPAYLOAD  = 3'd6,
    lpDROP     = 3'd7
  } state_t;

  localparam logic [10:0] lpMIN_LEN = 11'(pMIN_PACKET_LENGHT);
  localparam logic [10:0] lpMAX_LEN = 11'(pMAX_PACKET_LENGHT);
  localparam logic [10:0] lpCNT_SAT = 11'h7FF;

  state_t                    state_q, state_d, cls;
  logic [2:0]                fcnt_q, fcnt_d;
  logic [10:0]               cnt_q, cnt_d;
  logic                      frame_end, in_frame, abort, crc_bad, len_bad;
  logic                      dv_q, dv_d, er_q, er_d, stat_q, stat_d;
  logic [pDATA_WIDTH-1:0]    d_q, d_d;
  logic [pFSM_BUS_WIDHT-1:0] fs_q, fs_d;
  logic [10:0]               len_q, len_d;

`ifdef RX_CRC_CHECK_EN
  localparam logic [31:0] lpCRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] lpCRC_RESIDUE = 32'hDEBB_20E3;
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_bad = (crc_q != lpCRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // cls is the class of the byte now on igmii_d; state_q is the class of the previous byte.
  always_comb begin
    cls       = state_q;
    fcnt_d    = fcnt_q;
    frame_end = 1'b0;
    case (state_q)
      lpIDLE: begin
        if (!igmii_dv)              cls = lpIDLE;
        else if (igmii_d == 8'h55)  cls = lpPREAMBLE;
        else                        cls = lpDROP;
      end
      lpPREAMBLE: begin
        if (!igmii_dv)              cls = lpIDLE;
        else if (igmii_d == 8'h55)  cls = lpPREAMBLE;
        else if (igmii_d == 8'hD5)  cls = lpSFD;
        else                        cls = lpDROP;
      end
      lpDROP: cls = igmii_dv ? lpDROP : lpIDLE;
      default: begin
        if (!igmii_dv) begin
          cls       = lpIDLE;
          frame_end = 1'b1;
        end else begin
          case (state_q)
            lpSFD: begin
              cls    = lpDA;
              fcnt_d = 3'd5;
            end
            lpDA: begin
              if (fcnt_q == 3'd0) begin
                cls    = lpSA;
                fcnt_d = 3'd5;
              end else begin
                cls    = lpDA;
                fcnt_d = fcnt_q - 3'd1;
              end
            end
            lpSA: begin
              if (fcnt_q == 3'd0) begin
                cls    = lpTYPE;
                fcnt_d = 3'd1;
              end else begin
                cls    = lpSA;
                fcnt_d = fcnt_q - 3'd1;
              end
            end
            lpTYPE: begin
              if (fcnt_q == 3'd0) cls = lpPAYLOAD;
              else begin
                cls    = lpTYPE;
                fcnt_d = fcnt_q - 3'd1;
              end
            end
            default: cls = lpPAYLOAD;
          endcase
        end
      end
    endcase
  end

  assign in_frame = (cls == lpSFD) || (cls == lpDA) || (cls == lpSA) ||
                    (cls == lpTYPE) || (cls == lpPAYLOAD);
  assign abort    = igmii_dv & igmii_er & in_frame;
  assign len_bad  = (cnt_q < lpMIN_LEN) || (cnt_q > lpMAX_LEN);

  always_comb begin
    state_d = abort ? lpDROP : cls;
    fs_d    = pFSM_BUS_WIDHT'(state_d);
    dv_d    = in_frame & ~abort;
    d_d     = dv_d ? igmii_d : '0;
    er_d    = abort | (frame_end & (crc_bad | len_bad));
    stat_d  = frame_end;
    len_d   = frame_end ? cnt_q : 11'd0;
    cnt_d   = cnt_q;
    if (dv_d && cls == lpSFD)           cnt_d = 11'd0;
    else if (dv_d && cnt_q != lpCNT_SAT) cnt_d = cnt_q + 11'd1;
`ifdef RX_CRC_CHECK_EN
    crc_d = crc_q;
    if (dv_d && cls == lpSFD) crc_d = lpCRC_INIT;
    else if (dv_d)            crc_d = crc32_byte(crc_q, igmii_d);
`endif
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= lpIDLE;
      fcnt_q  <= 3'd0;
      cnt_q   <= 11'd0;
      dv_q    <= 1'b0;
      d_q     <= '0;
      er_q    <= 1'b0;
      fs_q    <= '0;
      stat_q  <= 1'b0;
      len_q   <= 11'd0;
`ifdef RX_CRC_CHECK_EN
      crc_q   <= lpCRC_INIT;
`endif
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      d_q     <= d_d;
      er_q    <= er_d;
      fs_q    <= fs_d;
      stat_q  <= stat_d;
      len_q   <= len_d;
`ifdef RX_CRC_CHECK_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign odv           = dv_q;
  assign orx_d         = d_q;
  assign orx_er        = er_q;
  assign oframe_state  = fs_q;
  assign ostatus_valid = stat_q;
  assign olen          = len_q;

endmodule
